// File: rtl/game_tick_sched_pkg.sv
// Shared definitions for the game tick scheduler: state encoding, widths, scroll-period helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package game_pkg;

    localparam int LEVEL_W  = 4;
    // Wide enough for the largest divider (1666667 < 2^21).
    localparam int PERIOD_W = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    // Scroll period for a level, floored at pmin. The compare is done before the
    // subtraction so the period can never wrap below zero.
    function automatic logic [PERIOD_W-1:0] scroll_period(
        input logic [LEVEL_W-1:0]  lvl,
        input logic [PERIOD_W-1:0] base,
        input logic [PERIOD_W-1:0] step,
        input logic [PERIOD_W-1:0] pmin
    );
        logic [PERIOD_W-1:0] dec;
        dec = PERIOD_W'(lvl) * step;
        if (dec >= (base - pmin)) begin
            scroll_period = pmin;
        end else begin
            scroll_period = base - dec;
        end
    endfunction

endpackage

// File: rtl/game_tick_sched_tick_counter.sv
// Generic enable-driven divider: counts en pulses, emits a one-cycle tick on terminal count.
// Latency: tick_o one cycle after the enabled cycle at terminal; fire_o is the same-cycle strobe.
// Backpressure: none; en low holds the count, clr forces zero and drops any pending tick.
module tick_counter
    import game_pkg::*;
#(
    parameter int W = PERIOD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] period_i,
    output logic         fire_o,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         tick_q;
    logic         term;

    // Greater-or-equal so a period that shrinks below the current count still wraps.
    assign term   = (cnt_q >= (period_i - W'(1)));
    assign fire_o = en_i && !clr_i && term;
    assign tick_o = tick_q;

    // Next count: clear wins, otherwise advance or wrap when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = term ? '0 : (cnt_q + W'(1));
        end
    end

    // Count and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= fire_o;
        end
    end

endmodule

// File: rtl/game_tick_sched.sv
// Game timing scheduler: run/pause/over sequencing plus frame, scroll and animation enable ticks.
// Latency: all outputs registered; first frame_tick FRAME_DIV cycles after entering RUN.
// Backpressure: pause or game_over freeze every counter; a tick due in that cycle is dropped.
module game_tick_sched
    import game_pkg::*;
#(
    parameter int FRAME_DIV    = 1666667,
    parameter int SCROLL_BASE  = 400000,
    parameter int SCROLL_STEP  = 25000,
    parameter int SCROLL_MIN   = 100000,
    parameter int LEVEL_FRAMES = 600,
    parameter int ANIM_DIV     = 6,
    parameter int MAX_LEVEL    = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       game_over,
    output logic       frame_tick,
    output logic       scroll_tick,
    output logic       anim_tick,
    output logic [3:0] level,
    output logic [1:0] state,
    output logic       running
);

    localparam int ANIM_W = $clog2(ANIM_DIV + 1);
    localparam int LF_W   = $clog2(LEVEL_FRAMES + 1);

    state_e               state_q;
    logic                 running_q;
    logic [LEVEL_W-1:0]   level_q;
    logic                 cnt_en;
    logic                 cnt_clr;
    logic                 frame_fire;
    logic                 scroll_fire;
    logic                 anim_fire;
    logic                 lf_fire;
    logic                 lf_tick;
    logic [PERIOD_W-1:0]  scroll_per;
    logic                 unused_fire;

    // Counting only in RUN; the cycle pause/game_over is sampled is already frozen.
    assign cnt_en  = (state_q == ST_RUN) && !pause && !game_over;
    // Held at zero in IDLE, and wiped on the restart edge out of OVER.
    assign cnt_clr = (state_q == ST_IDLE) || ((state_q == ST_OVER) && start);

    assign scroll_per = scroll_period(level_q, PERIOD_W'(SCROLL_BASE),
                                      PERIOD_W'(SCROLL_STEP), PERIOD_W'(SCROLL_MIN));

    tick_counter #(.W(PERIOD_W)) u_frame (
        .clk(clk), .rst_n(rst_n), .en_i(cnt_en), .clr_i(cnt_clr),
        .period_i(PERIOD_W'(FRAME_DIV)), .fire_o(frame_fire), .tick_o(frame_tick)
    );

    tick_counter #(.W(PERIOD_W)) u_scroll (
        .clk(clk), .rst_n(rst_n), .en_i(cnt_en), .clr_i(cnt_clr),
        .period_i(scroll_per), .fire_o(scroll_fire), .tick_o(scroll_tick)
    );

    // Frame-rate counters step on the frame strobe so their ticks line up with frame_tick.
    tick_counter #(.W(ANIM_W)) u_anim (
        .clk(clk), .rst_n(rst_n), .en_i(frame_fire), .clr_i(cnt_clr),
        .period_i(ANIM_W'(ANIM_DIV)), .fire_o(anim_fire), .tick_o(anim_tick)
    );

    tick_counter #(.W(LF_W)) u_level_frames (
        .clk(clk), .rst_n(rst_n), .en_i(frame_fire), .clr_i(cnt_clr),
        .period_i(LF_W'(LEVEL_FRAMES)), .fire_o(lf_fire), .tick_o(lf_tick)
    );

    assign unused_fire = scroll_fire | anim_fire | lf_tick;

    // Game state sequencing with registered running flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (game_over) begin
                        state_q   <= ST_OVER;
                        running_q <= 1'b0;
                    end else if (pause) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (game_over) begin
                        state_q   <= ST_OVER;
                    end else if (!pause) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Speed level: bumps on the frame that completes a level block, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else if (cnt_clr) begin
            level_q <= '0;
        end else if (lf_fire && (level_q < LEVEL_W'(MAX_LEVEL))) begin
            level_q <= level_q + LEVEL_W'(1);
        end
    end

    assign level   = level_q;
    assign state   = state_q;
    assign running = running_q;

endmodule

// File: tb/tb_game_tick_sched.sv
module tb_game_tick_sched;

    typedef struct {
        int         cyc;
        logic       start;
        logic       pause;
        logic       gov;
        logic [1:0] st;
        logic       ft;
        logic       sc;
        logic       an;
        logic [3:0] lvl;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic       game_over;
    logic       frame_tick;
    logic       scroll_tick;
    logic       anim_tick;
    logic [3:0] level;
    logic [1:0] state;
    logic       running;

    logic       tc_en;
    logic       tc_clr;
    logic [7:0] tc_per;
    logic       tc_fire;
    logic       tc_tick;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[$];

    game_tick_sched #(
        .FRAME_DIV(10), .SCROLL_BASE(20), .SCROLL_STEP(4), .SCROLL_MIN(8),
        .LEVEL_FRAMES(3), .ANIM_DIV(2), .MAX_LEVEL(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .game_over(game_over),
        .frame_tick(frame_tick), .scroll_tick(scroll_tick), .anim_tick(anim_tick),
        .level(level), .state(state), .running(running)
    );

    tick_counter #(.W(8)) u_tc (
        .clk(clk), .rst_n(rst_n), .en_i(tc_en), .clr_i(tc_clr),
        .period_i(tc_per), .fire_o(tc_fire), .tick_o(tc_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic add(input int c, input logic s, input logic p, input logic g,
                       input logic [1:0] st, input logic ft, input logic sc,
                       input logic an, input logic [3:0] lv);
        vec_t v;
        v.cyc = c; v.start = s; v.pause = p; v.gov = g;
        v.st = st; v.ft = ft; v.sc = sc; v.an = an; v.lvl = lv;
        tbl.push_back(v);
    endtask

    initial begin
        int vi;
        int n_ft, n_sc, n_an;
        int win_ticks;
        int dbl_ticks;
        int early;
        logic pft, psc, pan;
        logic [9:0] got_v, exp_v;

        //   cyc  st pa go  state ft sc an lvl
        add(  0, 1, 0, 0, 2'd0, 0, 0, 0, 4'd0);
        add(  1, 0, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add( 10, 0, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add( 11, 0, 0, 0, 2'd1, 1, 0, 0, 4'd0);
        add( 12, 0, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add( 20, 0, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add( 21, 0, 0, 0, 2'd1, 1, 1, 1, 4'd0);
        add( 31, 0, 0, 0, 2'd1, 1, 0, 0, 4'd1);
        add( 36, 0, 0, 0, 2'd1, 0, 0, 0, 4'd1);
        add( 37, 0, 0, 0, 2'd1, 0, 1, 0, 4'd1);
        add( 41, 0, 0, 0, 2'd1, 1, 0, 1, 4'd1);
        add( 53, 0, 0, 0, 2'd1, 0, 1, 0, 4'd1);
        add( 61, 0, 0, 0, 2'd1, 1, 0, 1, 4'd2);
        add( 65, 0, 0, 0, 2'd1, 0, 1, 0, 4'd2);
        add( 91, 0, 0, 0, 2'd1, 1, 0, 0, 4'd3);
        add( 97, 0, 0, 0, 2'd1, 0, 1, 0, 4'd3);
        add(121, 0, 0, 0, 2'd1, 1, 1, 1, 4'd4);
        add(151, 0, 0, 0, 2'd1, 1, 0, 0, 4'd4);
        add(161, 0, 0, 0, 2'd1, 1, 1, 1, 4'd4);
        add(301, 0, 0, 0, 2'd1, 1, 0, 1, 4'd4);
        add(305, 0, 0, 0, 2'd1, 0, 1, 0, 4'd4);
        add(306, 0, 1, 0, 2'd1, 0, 0, 0, 4'd4);
        add(307, 0, 1, 0, 2'd2, 0, 0, 0, 4'd4);
        add(311, 0, 1, 0, 2'd2, 0, 0, 0, 4'd4);
        add(343, 0, 0, 0, 2'd2, 0, 0, 0, 4'd4);
        add(344, 0, 0, 0, 2'd1, 0, 0, 0, 4'd4);
        add(348, 0, 0, 0, 2'd1, 0, 0, 0, 4'd4);
        add(349, 0, 0, 0, 2'd1, 1, 0, 0, 4'd4);
        add(351, 0, 0, 0, 2'd1, 0, 1, 0, 4'd4);
        add(358, 0, 1, 1, 2'd1, 0, 0, 0, 4'd4);
        add(359, 0, 1, 0, 2'd3, 0, 0, 0, 4'd4);
        add(363, 0, 0, 0, 2'd3, 0, 0, 0, 4'd4);
        add(370, 1, 0, 0, 2'd3, 0, 0, 0, 4'd4);
        add(371, 0, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add(380, 0, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add(381, 0, 0, 0, 2'd1, 1, 0, 0, 4'd0);
        add(385, 1, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add(386, 0, 0, 0, 2'd1, 0, 0, 0, 4'd0);
        add(391, 0, 0, 0, 2'd1, 1, 1, 1, 4'd0);
        add(401, 0, 0, 0, 2'd1, 1, 0, 0, 4'd1);

        start = 1'b0; pause = 1'b0; game_over = 1'b0;
        tc_en = 1'b0; tc_clr = 1'b1; tc_per = 8'd16;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ticks", int'({frame_tick, scroll_tick, anim_tick}), 0);
        chk("rst_running", int'(running), 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vi = 0; n_ft = 0; n_sc = 0; n_an = 0; win_ticks = 0; dbl_ticks = 0;
        pft = 1'b0; psc = 1'b0; pan = 1'b0;
        for (int c = 0; c <= 401; c++) begin
            if (c > 0) @(negedge clk);
            start = 1'b0;
            game_over = 1'b0;

            if (frame_tick)  n_ft++;
            if (scroll_tick) n_sc++;
            if (anim_tick)   n_an++;
            if ((pft && frame_tick) || (psc && scroll_tick) || (pan && anim_tick)) dbl_ticks++;
            pft = frame_tick; psc = scroll_tick; pan = anim_tick;
            if (((c >= 307) && (c <= 343)) || ((c >= 359) && (c <= 370)))
                if (frame_tick || scroll_tick || anim_tick) win_ticks++;

            if ((vi < tbl.size()) && (tbl[vi].cyc == c)) begin
                got_v = {state, running, frame_tick, scroll_tick, anim_tick, level};
                exp_v = {tbl[vi].st, (tbl[vi].st == 2'd1), tbl[vi].ft, tbl[vi].sc,
                         tbl[vi].an, tbl[vi].lvl};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL vec_c%0d: got st/run/ft/sc/an/lvl=%b required %b",
                             c, got_v, exp_v);
                end
                start     = tbl[vi].start;
                pause     = tbl[vi].pause;
                game_over = tbl[vi].gov;
                vi++;
            end

            if (c == 305) begin
                chk("frames_30", n_ft, 30);
                chk("scrolls_to_305", n_sc, 33);
                chk("anims_to_305", n_an, 15);
            end
        end
        chk("vectors_applied", vi, tbl.size());
        chk("no_ticks_paused_or_over", win_ticks, 0);
        chk("no_back_to_back_ticks", dbl_ticks, 0);

        // Reset asserted in the middle of a frame_tick cycle.
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_frame_tick", int'(frame_tick), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_running", int'(running), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        early = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (frame_tick || scroll_tick || anim_tick || (state != 2'd0)) early++;
        end
        chk("idle_quiet_after_reset", early, 0);

        // Period shrinking below the live count on the bare counter.
        @(negedge clk);
        tc_clr = 1'b0;
        tc_en  = 1'b1;
        early  = 0;
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk);
            if (tc_tick) early++;
        end
        chk("shrink_fire_before", int'(tc_fire), 0);
        tc_per = 8'd12;
        #1;
        chk("shrink_fire_after", int'(tc_fire), 1);
        @(negedge clk);
        chk("shrink_tick_next", int'(tc_tick), 1);
        for (int k = 17; k <= 27; k++) begin
            @(negedge clk);
            if (tc_tick) early++;
        end
        @(negedge clk);
        chk("shrink_wrap_period", int'(tc_tick), 1);
        chk("shrink_no_stray_ticks", early, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_tick_sched.md
Name: game_tick_sched

Overview:
- Central timing scheduler for the T-rex game. It replaces free-running divided clocks with single-cycle enable pulses on the system clock.
- Outputs: frame tick, obstacle-scroll tick and sprite-animation tick.
- Sequences game state (idle/run/pause/over) and raises a speed level over time, which shortens the scroll period.
- Sits between top-level button/collision logic and the render, obstacle and dino-animation blocks.

Parameters:
- FRAME_DIV, 1666667, clk cycles per frame_tick (100 MHz to 60 Hz).
- SCROLL_BASE, 400000, scroll period in clk cycles at level 0.
- SCROLL_STEP, 25000, cycles removed from the scroll period per level.
- SCROLL_MIN, 100000, floor of the scroll period.
- LEVEL_FRAMES, 600, frame_ticks per level increment.
- ANIM_DIV, 6, frame_ticks per anim_tick.
- MAX_LEVEL, 12, saturation value of level (must be ≤15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begin or restart game.
- pause  in  1  level; hold game while high.
- game_over  in  1  single-cycle pulse from collision logic.
- frame_tick  out  1  one-cycle enable, once per frame.
- scroll_tick  out  1  one-cycle enable per obstacle scroll step.
- anim_tick  out  1  one-cycle enable per animation step.
- level  out  4  current speed level.
- state  out  2  0=IDLE, 1=RUN, 2=PAUSED, 3=OVER.
- running  out  1  high iff state==RUN.

Behaviour:
- Reset (async, rst_n low): state=IDLE, level=0, all counters=0, all ticks=0, running=0.
- All outputs are registered. Ticks are never high for two consecutive cycles.
- FSM, evaluated per clk edge, priority top-down:
  - IDLE: start → RUN. Counters and level are cleared.
  - RUN: game_over → OVER. Otherwise pause → PAUSED. Otherwise count.
  - PAUSED: game_over → OVER. Otherwise !pause → RUN. Counters are held.
  - OVER: start → RUN. Counters and level are cleared in the same edge. pause is ignored.
  - start is ignored in RUN and PAUSED.
- Counters advance only in RUN. They hold in PAUSED and OVER, and are held at 0 in IDLE.
- frame counter: counts 0..FRAME_DIV-1 and wraps.
  - frame_tick is high the cycle after the counter reaches FRAME_DIV-1.
  - First frame_tick is high exactly FRAME_DIV cycles after the edge that enters RUN.
- Scroll period: P = max(SCROLL_BASE - level*SCROLL_STEP, SCROLL_MIN). Compute in ≥21-bit unsigned arithmetic with no underflow: if level*SCROLL_STEP ≥ SCROLL_BASE - SCROLL_MIN, P = SCROLL_MIN.
- Scroll counter: terminal test is cnt ≥ P-1, not equality. If a level increase shrinks P below the current count, scroll_tick fires on the next cycle and the counter wraps to 0.
- anim_tick: coincides with every ANIM_DIV-th frame_tick (frame-tick counter 0..ANIM_DIV-1).
- level: increments on the frame_tick that completes LEVEL_FRAMES frames and saturates at MAX_LEVEL. The frames-per-level counter keeps wrapping after saturation.
- Tick suppression: if game_over or pause is sampled in the same cycle a counter hits terminal, no tick is emitted and the counter holds.
- On resume from PAUSED, counting continues from the held values. Remaining cycles to the next tick are unchanged.
- Reset mid-game: immediate IDLE. Any pending tick is cleared asynchronously.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants ST_IDLE/ST_RUN/ST_PAUSED/ST_OVER;
  - LEVEL_W=4;
  - the period-width constant.
- Sub-module tick_counter: parameterised-width counter with inputs en, clr and period, a ≥ terminal compare, and a registered tick output.
  - Instantiated for frame, scroll, anim and level-frames.
  - anim and level-frames instances use frame_tick as en.

Test Plan (small params: FRAME_DIV=10, SCROLL_BASE=20, SCROLL_STEP=4, SCROLL_MIN=8, LEVEL_FRAMES=3, ANIM_DIV=2, MAX_LEVEL=4):
- Reset, then start at cycle 0 → state=1 from cycle 1, first frame_tick at cycle 11 then every 10; scroll_tick every 20; anim_tick on every 2nd frame_tick.
- Run 30 frames → level goes 1,2,3,4 at frames 3,6,9,12, then stays 4. Scroll period goes 20,16,12,8, then stays at 8 (floor reached at level 3, level 4 floored).
- Level 1→2 while scroll count is 14 (new P=12) → scroll_tick the next cycle, counter wraps to 0.
- pause high for 37 cycles, 5 cycles before a frame_tick due → no ticks while paused, state=2. frame_tick occurs 5 RUN cycles after pause drops.
- game_over and pause in the same cycle that frame_tick would fire → state=3, no tick. start → state=1, level=0, next frame_tick 10 cycles later.
- rst_n low mid-RUN on the cycle a tick is high → tick, level and state go to 0 immediately. start before start-of-IDLE is ignored in RUN.
